// File: rtl/reg_scoreboard.sv
// Register scoreboard: a per-register pending-write counter table that stalls
// decode on read-after-write hazards and on counter saturation.
module reg_scoreboard #(
   parameter int NREGS     = 32,
   parameter int AW        = 5,
   parameter int NRD       = 2,
   parameter int NWR       = 2,
   parameter int CW        = 3,
   parameter bit WB_BYPASS = 1'b0,
   parameter bit R0_ZERO   = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              issue_valid,
   input  logic [NWR-1:0]    issue_wr_en,
   input  logic [NWR*AW-1:0] issue_wr_addr,
   input  logic [NRD-1:0]    rd_en,
   input  logic [NRD*AW-1:0] rd_addr,
   input  logic [NWR-1:0]    wb_en,
   input  logic [NWR*AW-1:0] wb_addr,
   input  logic              flush,
   output logic              stall,
   output logic              issue_ack,
   output logic [NREGS-1:0]  busy,
   output logic              err_underflow
);

   // Sum width holds cnt plus NWR increments without overflow.
   localparam int SW = CW + $clog2(NWR + 1) + 1;
   localparam logic [SW-1:0] CMAX = SW'((1 << CW) - 1);

   logic [CW-1:0] cnt      [NREGS];
   logic [CW-1:0] cnt_next [NREGS];
   logic [SW-1:0] req      [NREGS];
   logic [SW-1:0] inc      [NREGS];
   logic [SW-1:0] dec      [NREGS];
   logic          rd_hazard;
   logic          sat_hazard;
   logic          err_next;

   function automatic logic tracked(input logic [AW-1:0] a);
      return (int'(a) < NREGS) && !(R0_ZERO && (a == '0));
   endfunction

   // Requested destinations and releases, independent of the ack.
   always_comb begin
      for (int r = 0; r < NREGS; r++) begin
         req[r] = '0;
         dec[r] = '0;
      end
      for (int i = 0; i < NWR; i++) begin
         if (issue_valid && issue_wr_en[i] && tracked(issue_wr_addr[i*AW +: AW]))
            req[issue_wr_addr[i*AW +: AW]] = req[issue_wr_addr[i*AW +: AW]] + SW'(1);
         if (wb_en[i] && tracked(wb_addr[i*AW +: AW]))
            dec[wb_addr[i*AW +: AW]] = dec[wb_addr[i*AW +: AW]] + SW'(1);
      end
   end

   always_comb begin
      rd_hazard = 1'b0;
      for (int i = 0; i < NRD; i++) begin
         if (issue_valid && rd_en[i] && tracked(rd_addr[i*AW +: AW]) &&
             (cnt[rd_addr[i*AW +: AW]] != '0)) begin
            if (!WB_BYPASS || (SW'(cnt[rd_addr[i*AW +: AW]]) != dec[rd_addr[i*AW +: AW]]))
               rd_hazard = 1'b1;
         end
      end
   end

   always_comb begin
      sat_hazard = 1'b0;
      for (int r = 0; r < NREGS; r++) begin
         if (SW'(cnt[r]) + req[r] > CMAX + dec[r])
            sat_hazard = 1'b1;
      end
   end

   assign stall     = rst & (flush | rd_hazard | sat_hazard);
   assign issue_ack = issue_valid & ~stall & ~flush & rst;

   // Increments only count once the instruction is actually accepted.
   always_comb begin
      for (int r = 0; r < NREGS; r++)
         inc[r] = '0;
      for (int i = 0; i < NWR; i++) begin
         if (issue_ack && issue_wr_en[i] && tracked(issue_wr_addr[i*AW +: AW]))
            inc[issue_wr_addr[i*AW +: AW]] = inc[issue_wr_addr[i*AW +: AW]] + SW'(1);
      end
   end

   always_comb begin
      err_next = err_underflow;
      for (int r = 0; r < NREGS; r++) begin
         if (dec[r] > SW'(cnt[r]) + inc[r]) begin
            cnt_next[r] = '0;
            err_next    = 1'b1;
         end else begin
            cnt_next[r] = CW'(SW'(cnt[r]) + inc[r] - dec[r]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int r = 0; r < NREGS; r++)
            cnt[r] <= '0;
         busy          <= '0;
         err_underflow <= 1'b0;
      end else if (flush) begin
         for (int r = 0; r < NREGS; r++)
            cnt[r] <= '0;
         busy <= '0;
      end else begin
         for (int r = 0; r < NREGS; r++) begin
            cnt[r]  <= cnt_next[r];
            busy[r] <= (cnt_next[r] != '0);
         end
         err_underflow <= err_next;
      end
   end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed vector table, random traffic against a
// counter-table reference model, and a short hand-written underflow sequence.
module tb_reg_scoreboard;

   localparam int NREGS     = 24;
   localparam int AW        = 5;
   localparam int NRD       = 2;
   localparam int NWR       = 2;
   localparam int CW        = 2;
   localparam bit WB_BYPASS = 1'b0;
   localparam bit R0_ZERO   = 1'b0;
   localparam int CMAX      = (1 << CW) - 1;

   typedef struct packed {
      logic                    rst;
      logic                    iv;
      logic                    fl;
      logic [NWR-1:0]          wen;
      logic [NWR-1:0][AW-1:0]  wa;
      logic [NRD-1:0]          ren;
      logic [NRD-1:0][AW-1:0]  ra;
      logic [NWR-1:0]          wben;
      logic [NWR-1:0][AW-1:0]  wba;
   } stim_t;

   typedef struct {
      stim_t            s;
      logic             es;
      logic             ea;
      logic [NREGS-1:0] eb;
      logic             ee;
      logic             cs;
   } vec_t;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              issue_valid = 1'b0;
   logic [NWR-1:0]    issue_wr_en = '0;
   logic [NWR*AW-1:0] issue_wr_addr = '0;
   logic [NRD-1:0]    rd_en = '0;
   logic [NRD*AW-1:0] rd_addr = '0;
   logic [NWR-1:0]    wb_en = '0;
   logic [NWR*AW-1:0] wb_addr = '0;
   logic              flush = 1'b0;
   logic              stall;
   logic              issue_ack;
   logic [NREGS-1:0]  busy;
   logic              err_underflow;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: pending write count per register and the sticky error.
   int               exp_cnt [NREGS];
   bit               exp_err = 1'b0;
   logic [NREGS-1:0] exp_q[$];
   vec_t             tbl[$];

   reg_scoreboard #(
      .NREGS(NREGS), .AW(AW), .NRD(NRD), .NWR(NWR), .CW(CW),
      .WB_BYPASS(WB_BYPASS), .R0_ZERO(R0_ZERO)
   ) dut (
      .clk(clk), .rst(rst), .issue_valid(issue_valid),
      .issue_wr_en(issue_wr_en), .issue_wr_addr(issue_wr_addr),
      .rd_en(rd_en), .rd_addr(rd_addr),
      .wb_en(wb_en), .wb_addr(wb_addr), .flush(flush),
      .stall(stall), .issue_ack(issue_ack),
      .busy(busy), .err_underflow(err_underflow)
   );

   always #5 clk = ~clk;

   function automatic bit tracked(input int a);
      return (a < NREGS) && !(R0_ZERO && a == 0);
   endfunction

   function automatic logic [NREGS-1:0] b(input int r);
      logic [NREGS-1:0] v;
      v = '0;
      v[r] = 1'b1;
      return v;
   endfunction

   function automatic vec_t mk(input logic r, input logic iv,
                               input logic [1:0] wen, input int wa0, input int wa1,
                               input logic [1:0] ren, input int ra0, input int ra1,
                               input logic [1:0] wben, input int wb0, input int wb1,
                               input logic fl, input logic es, input logic ea,
                               input logic [NREGS-1:0] eb, input logic ee, input logic cs);
      vec_t v;
      v.s.rst = r;  v.s.iv = iv;  v.s.fl = fl;
      v.s.wen = wen;  v.s.wa[0] = AW'(wa0);  v.s.wa[1] = AW'(wa1);
      v.s.ren = ren;  v.s.ra[0] = AW'(ra0);  v.s.ra[1] = AW'(ra1);
      v.s.wben = wben; v.s.wba[0] = AW'(wb0); v.s.wba[1] = AW'(wb1);
      v.es = es; v.ea = ea; v.eb = eb; v.ee = ee; v.cs = cs;
      return v;
   endfunction

   function automatic void predict(input stim_t s, output logic st, output logic ak);
      int req [NREGS];
      int rel [NREGS];
      bit hz;
      foreach (req[r]) begin req[r] = 0; rel[r] = 0; end
      for (int i = 0; i < NWR; i++) begin
         if (s.iv && s.wen[i] && tracked(int'(s.wa[i]))) req[s.wa[i]]++;
         if (s.wben[i] && tracked(int'(s.wba[i]))) rel[s.wba[i]]++;
      end
      hz = s.fl;
      for (int i = 0; i < NRD; i++) begin
         if (s.iv && s.ren[i] && tracked(int'(s.ra[i])) && exp_cnt[s.ra[i]] > 0 &&
             !(WB_BYPASS && exp_cnt[s.ra[i]] == rel[s.ra[i]]))
            hz = 1'b1;
      end
      for (int r = 0; r < NREGS; r++)
         if (exp_cnt[r] + req[r] - rel[r] > CMAX) hz = 1'b1;
      st = s.rst && hz;
      ak = s.rst && s.iv && !st;
   endfunction

   function automatic void model_update(input stim_t s, input logic ak);
      int n;
      int add [NREGS];
      int rel [NREGS];
      if (!s.rst || s.fl) begin
         foreach (exp_cnt[r]) exp_cnt[r] = 0;
         if (!s.rst) exp_err = 1'b0;
         return;
      end
      foreach (add[r]) begin add[r] = 0; rel[r] = 0; end
      for (int i = 0; i < NWR; i++) begin
         if (ak && s.wen[i] && tracked(int'(s.wa[i]))) add[s.wa[i]]++;
         if (s.wben[i] && tracked(int'(s.wba[i]))) rel[s.wba[i]]++;
      end
      for (int r = 0; r < NREGS; r++) begin
         n = exp_cnt[r] + add[r] - rel[r];
         if (n < 0) begin n = 0; exp_err = 1'b1; end
         exp_cnt[r] = n;
      end
   endfunction

   function automatic logic [NREGS-1:0] model_busy();
      logic [NREGS-1:0] v;
      for (int r = 0; r < NREGS; r++) v[r] = (exp_cnt[r] != 0);
      return v;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // One cycle: drive at negedge, compare just after, advance the model at posedge.
   task automatic step(input vec_t v, input bit use_model, input string tag);
      logic m_st, m_ak;
      logic [NREGS-1:0] m_busy;
      @(negedge clk);
      rst = v.s.rst;  issue_valid = v.s.iv;  flush = v.s.fl;
      issue_wr_en = v.s.wen;  issue_wr_addr = v.s.wa;
      rd_en = v.s.ren;  rd_addr = v.s.ra;
      wb_en = v.s.wben;  wb_addr = v.s.wba;
      #1;
      m_busy = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      predict(v.s, m_st, m_ak);
      if (use_model) begin
         check({tag, "_stall"}, 32'(stall), 32'(m_st));
         check({tag, "_ack"}, 32'(issue_ack), 32'(m_ak));
         check({tag, "_busy"}, 32'(busy), 32'(m_busy));
         check({tag, "_err"}, 32'(err_underflow), 32'(exp_err));
      end else begin
         check({tag, "_stall"}, 32'(stall), 32'(v.es));
         check({tag, "_ack"}, 32'(issue_ack), 32'(v.ea));
         if (v.cs) begin
            check({tag, "_busy"}, 32'(busy), 32'(v.eb));
            check({tag, "_err"}, 32'(err_underflow), 32'(v.ee));
         end
      end
      @(posedge clk);
      model_update(v.s, m_ak);
      exp_q.push_back(model_busy());
   endtask

   function automatic int rand_addr();
      return ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
   endfunction

   initial begin
      vec_t  v;
      int    pend [NREGS];
      int    r;

      // rst, iv, wen, wa0, wa1, ren, ra0, ra1, wben, wb0, wb1, fl, stall, ack, busy, err, check_state
      tbl.push_back(mk(0,1,2'b01,3,0, 2'b00,0,0, 2'b00,0,0, 0, 0,0, '0,    0,0));
      tbl.push_back(mk(0,1,2'b01,3,0, 2'b01,3,0, 2'b00,0,0, 0, 0,0, '0,    0,1));
      tbl.push_back(mk(1,1,2'b01,3,0, 2'b00,0,0, 2'b00,0,0, 0, 0,1, '0,    0,1));
      tbl.push_back(mk(1,1,2'b00,0,0, 2'b01,3,0, 2'b00,0,0, 0, 1,0, b(3),  0,1));
      tbl.push_back(mk(1,1,2'b00,0,0, 2'b01,3,0, 2'b01,3,0, 0, 1,0, b(3),  0,1));
      tbl.push_back(mk(1,1,2'b00,0,0, 2'b01,3,0, 2'b00,0,0, 0, 0,1, '0,    0,1));
      tbl.push_back(mk(1,1,2'b11,5,5, 2'b00,0,0, 2'b00,0,0, 0, 0,1, '0,    0,1));
      tbl.push_back(mk(1,0,2'b00,0,0, 2'b00,0,0, 2'b01,5,0, 0, 0,0, b(5),  0,1));
      tbl.push_back(mk(1,0,2'b00,0,0, 2'b00,0,0, 2'b00,0,0, 0, 0,0, b(5),  0,1));
      tbl.push_back(mk(1,0,2'b00,0,0, 2'b00,0,0, 2'b10,0,5, 0, 0,0, b(5),  0,1));
      tbl.push_back(mk(1,0,2'b00,0,0, 2'b00,0,0, 2'b00,0,0, 0, 0,0, '0,    0,1));
      tbl.push_back(mk(1,1,2'b01,7,0, 2'b00,0,0, 2'b00,0,0, 0, 0,1, '0,    0,1));
      tbl.push_back(mk(1,1,2'b01,7,0, 2'b00,0,0, 2'b00,0,0, 0, 0,1, b(7),  0,1));
      tbl.push_back(mk(1,1,2'b01,7,0, 2'b00,0,0, 2'b00,0,0, 0, 0,1, b(7),  0,1));
      tbl.push_back(mk(1,1,2'b01,7,0, 2'b00,0,0, 2'b00,0,0, 0, 1,0, b(7),  0,1));
      tbl.push_back(mk(1,1,2'b01,7,0, 2'b00,0,0, 2'b01,7,0, 0, 0,1, b(7),  0,1));
      tbl.push_back(mk(1,1,2'b11,7,7, 2'b00,0,0, 2'b11,7,7, 0, 0,1, b(7),  0,1));
      tbl.push_back(mk(1,0,2'b00,0,0, 2'b00,0,0, 2'b11,7,7, 0, 0,0, b(7),  0,1));
      tbl.push_back(mk(1,0,2'b00,0,0, 2'b00,0,0, 2'b01,7,0, 0, 0,0, b(7),  0,1));
      tbl.push_back(mk(1,1,2'b01,2,0, 2'b00,0,0, 2'b00,0,0, 0, 0,1, '0,    0,1));
      tbl.push_back(mk(1,1,2'b01,2,0, 2'b00,0,0, 2'b01,2,0, 0, 0,1, b(2),  0,1));
      tbl.push_back(mk(1,0,2'b00,0,0, 2'b00,0,0, 2'b00,0,0, 0, 0,0, b(2),  0,1));
      tbl.push_back(mk(1,1,2'b11,4,4, 2'b00,0,0, 2'b00,0,0, 0, 0,1, b(2),  0,1));
      tbl.push_back(mk(1,1,2'b01,4,0, 2'b00,0,0, 2'b00,0,0, 1, 1,0, b(2)|b(4), 0,1));
      tbl.push_back(mk(1,0,2'b00,0,0, 2'b00,0,0, 2'b01,4,0, 0, 0,0, '0,    0,1));
      tbl.push_back(mk(1,0,2'b00,0,0, 2'b00,0,0, 2'b00,0,0, 0, 0,0, '0,    1,1));
      tbl.push_back(mk(1,1,2'b01,9,0, 2'b00,0,0, 2'b00,0,0, 0, 0,1, '0,    1,1));
      tbl.push_back(mk(0,1,2'b01,9,0, 2'b00,0,0, 2'b00,0,0, 0, 0,0, b(9),  1,1));
      tbl.push_back(mk(1,0,2'b00,0,0, 2'b00,0,0, 2'b00,0,0, 0, 0,0, '0,    0,1));
      tbl.push_back(mk(1,1,2'b01,30,0, 2'b01,30,0, 2'b00,0,0, 0, 0,1, '0,  0,1));
      tbl.push_back(mk(1,0,2'b00,0,0, 2'b00,0,0, 2'b01,30,0, 0, 0,0, '0,   0,1));
      tbl.push_back(mk(1,0,2'b00,0,0, 2'b00,0,0, 2'b00,0,0, 0, 0,0, '0,    0,1));
      tbl.push_back(mk(1,1,2'b10,0,6, 2'b00,0,0, 2'b00,0,0, 0, 0,1, '0,    0,1));
      tbl.push_back(mk(1,1,2'b00,0,0, 2'b10,0,6, 2'b00,0,0, 0, 1,0, b(6),  0,1));
      tbl.push_back(mk(1,0,2'b00,0,0, 2'b00,0,0, 2'b10,0,6, 0, 0,0, b(6),  0,1));
      tbl.push_back(mk(1,1,2'b00,0,0, 2'b10,0,6, 2'b00,0,0, 0, 0,1, '0,    0,1));

      for (int i = 0; i < tbl.size(); i++)
         step(tbl[i], 1'b0, $sformatf("tbl%0d", i));

      // Random traffic; releases mostly target registers the model holds pending.
      for (int n = 0; n < 400; n++) begin
         v = mk(1,0,2'b00,0,0, 2'b00,0,0, 2'b00,0,0, 0, 0,0, '0, 0,0);
         v.s.rst = ($urandom_range(0, 63) != 0);
         v.s.iv  = ($urandom_range(0, 9) < 7);
         v.s.fl  = ($urandom_range(0, 31) == 0);
         foreach (pend[k]) pend[k] = exp_cnt[k];
         for (int i = 0; i < NWR; i++) begin
            v.s.wen[i] = 1'($urandom_range(0, 1));
            v.s.wa[i]  = AW'(rand_addr());
            r = int'($urandom_range(0, NREGS - 1));
            if ($urandom_range(0, 39) == 0) begin
               v.s.wben[i] = 1'b1;
               v.s.wba[i]  = AW'(rand_addr());
            end else if (pend[r] > 0 && $urandom_range(0, 2) != 0) begin
               v.s.wben[i] = 1'b1;
               v.s.wba[i]  = AW'(r);
               pend[r]--;
            end
         end
         for (int i = 0; i < NRD; i++) begin
            v.s.ren[i] = 1'($urandom_range(0, 1));
            v.s.ra[i]  = AW'(rand_addr());
         end
         step(v, 1'b1, $sformatf("rnd%0d", n));
      end

      // Two releases against a single pending write: underflow, sticky until reset.
      step(mk(0,0,2'b00,0,0,   2'b00,0,0, 2'b00,0,0,   0, 0,0, '0,    0,0), 1'b0, "uf_rst");
      step(mk(1,1,2'b01,11,0,  2'b00,0,0, 2'b00,0,0,   0, 0,1, '0,    0,1), 1'b0, "uf_issue");
      step(mk(1,0,2'b00,0,0,   2'b00,0,0, 2'b11,11,11, 0, 0,0, b(11), 0,1), 1'b0, "uf_rel");
      step(mk(1,0,2'b00,0,0,   2'b00,0,0, 2'b00,0,0,   0, 0,0, '0,    1,1), 1'b0, "uf_sticky");
      step(mk(1,1,2'b00,0,0,   2'b01,11,0, 2'b00,0,0,  0, 0,1, '0,    1,1), 1'b0, "uf_read");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
